// File: rtl/alu_nic_rr.sv
// ============================================================================
// Module   : alu_nic_rr
// Brief    : Round-robin crossbar from N bus clients onto M shared ALU ports,
//            with a per-ALU stall watchdog that aborts and locks out the owner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_nic_rr #(
    parameter int CLIENTS_N = 4,
    parameter int ALUS_N    = 2,
    parameter int ALUS_W    = 1,
    parameter int DIN_W     = 210,
    parameter int DOUT_W    = 96,
    parameter int TMO_W     = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CLIENTS_N-1:0]        client_cycle,
    input  logic [CLIENTS_N-1:0]        client_strobe,
    output logic [CLIENTS_N-1:0]        client_ack,
    output logic [CLIENTS_N-1:0]        client_stall,
    output logic [CLIENTS_N-1:0]        client_err,
    input  logic [DIN_W*CLIENTS_N-1:0]  client_din,
    output logic [DOUT_W*CLIENTS_N-1:0] client_dout,
    output logic [CLIENTS_N-1:0]        client_gnt,
    output logic [ALUS_W*CLIENTS_N-1:0] client_gnt_id,
    output logic [ALUS_N-1:0]           alu_cycle,
    output logic [ALUS_N-1:0]           alu_strobe,
    input  logic [ALUS_N-1:0]           alu_ack,
    input  logic [ALUS_N-1:0]           alu_stall,
    output logic [DIN_W*ALUS_N-1:0]     alu_din,
    input  logic [DOUT_W*ALUS_N-1:0]    alu_dout
);

    localparam int               c_PTR_W     = (CLIENTS_N > 1) ? $clog2(CLIENTS_N) : 1;
    localparam logic [1:0]       c_ST_IDLE   = 2'd0;
    localparam logic [1:0]       c_ST_GRANT  = 2'd1;
    localparam logic [1:0]       c_ST_LOCK   = 2'd2;
    localparam logic [TMO_W-1:0] c_TMO_LIMIT = TMO_W'(TIMEOUT);

    logic [1:0]         r_state      [CLIENTS_N];
    logic [ALUS_W-1:0]  r_gnt_id     [CLIENTS_N];
    logic [CLIENTS_N-1:0] r_err;
    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [TMO_W-1:0]   r_stall_cnt  [ALUS_N];

    logic [1:0]         w_state_nxt  [CLIENTS_N];
    logic [ALUS_W-1:0]  w_gnt_id_nxt [CLIENTS_N];
    logic [ALUS_W-1:0]  w_arb_id     [CLIENTS_N];
    logic [CLIENTS_N-1:0] w_arb_gnt;
    logic [CLIENTS_N-1:0] w_err_nxt;
    logic [CLIENTS_N-1:0] w_timeout;
    logic [c_PTR_W-1:0] w_rr_ptr_nxt;
    logic [ALUS_N-1:0]  w_busy;
    logic [ALUS_N-1:0]  w_release;

    // An ALU is busy exactly while some client sits in GRANT pointing at it.
    always_comb begin
        w_busy = '0;
        for (int j = 0; j < CLIENTS_N; j++) begin
            if (r_state[j] == c_ST_GRANT) begin
                w_busy[r_gnt_id[j]] = 1'b1;
            end
        end
    end

    // Round-robin scan from r_rr_ptr; each IDLE requester takes the lowest free ALU.
    always_comb begin
        logic [ALUS_N-1:0] free;
        int                idx;
        int                last;
        logic              any;
        logic              found;
        free      = ~w_busy;
        idx       = 0;
        last      = int'(r_rr_ptr);
        any       = 1'b0;
        found     = 1'b0;
        w_arb_gnt = '0;
        for (int j = 0; j < CLIENTS_N; j++) begin
            w_arb_id[j] = '0;
        end
        for (int k = 0; k < CLIENTS_N; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= CLIENTS_N) begin
                idx = idx - CLIENTS_N;
            end
            if (client_cycle[idx] && (r_state[idx] == c_ST_IDLE)) begin
                found = 1'b0;
                for (int a = 0; a < ALUS_N; a++) begin
                    if (!found && free[a]) begin
                        found          = 1'b1;
                        free[a]        = 1'b0;
                        w_arb_gnt[idx] = 1'b1;
                        w_arb_id[idx]  = ALUS_W'(a);
                        any            = 1'b1;
                        last           = idx;
                    end
                end
            end
        end
        if (any) begin
            w_rr_ptr_nxt = (last == CLIENTS_N - 1) ? '0 : c_PTR_W'(last + 1);
        end else begin
            w_rr_ptr_nxt = r_rr_ptr;
        end
    end

    // A plain release (cycle dropped) is tested first so it wins over a timeout.
    always_comb begin
        w_release = '0;
        w_timeout = '0;
        w_err_nxt = '0;
        for (int j = 0; j < CLIENTS_N; j++) begin
            w_state_nxt[j]  = r_state[j];
            w_gnt_id_nxt[j] = r_gnt_id[j];
            w_timeout[j]    = (r_state[j] == c_ST_GRANT) &&
                              (r_stall_cnt[r_gnt_id[j]] == c_TMO_LIMIT);
            case (r_state[j])
                c_ST_IDLE: begin
                    if (w_arb_gnt[j]) begin
                        w_state_nxt[j]  = c_ST_GRANT;
                        w_gnt_id_nxt[j] = w_arb_id[j];
                    end
                end
                c_ST_GRANT: begin
                    if (!client_cycle[j]) begin
                        w_state_nxt[j]         = c_ST_IDLE;
                        w_gnt_id_nxt[j]        = '0;
                        w_release[r_gnt_id[j]] = 1'b1;
                    end else if (w_timeout[j]) begin
                        w_state_nxt[j]         = c_ST_LOCK;
                        w_gnt_id_nxt[j]        = '0;
                        w_err_nxt[j]           = 1'b1;
                        w_release[r_gnt_id[j]] = 1'b1;
                    end
                end
                c_ST_LOCK: begin
                    if (!client_cycle[j]) begin
                        w_state_nxt[j] = c_ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[j]  = c_ST_IDLE;
                    w_gnt_id_nxt[j] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
            r_err    <= '0;
            for (int j = 0; j < CLIENTS_N; j++) begin
                r_state[j]  <= c_ST_IDLE;
                r_gnt_id[j] <= '0;
            end
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
            r_err    <= w_err_nxt;
            for (int j = 0; j < CLIENTS_N; j++) begin
                r_state[j]  <= w_state_nxt[j];
                r_gnt_id[j] <= w_gnt_id_nxt[j];
            end
        end
    end

    // Stall watchdog: saturating, cleared whenever the ALU is idle, un-stalled or released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int a = 0; a < ALUS_N; a++) begin
                r_stall_cnt[a] <= '0;
            end
        end else begin
            for (int a = 0; a < ALUS_N; a++) begin
                if (w_release[a] || !w_busy[a]) begin
                    r_stall_cnt[a] <= '0;
                end else if (alu_cycle[a] && alu_stall[a]) begin
                    if (r_stall_cnt[a] != c_TMO_LIMIT) begin
                        r_stall_cnt[a] <= r_stall_cnt[a] + 1'b1;
                    end
                end else begin
                    r_stall_cnt[a] <= '0;
                end
            end
        end
    end

    always_comb begin
        alu_cycle    = '0;
        alu_strobe   = '0;
        alu_din      = '0;
        client_ack   = '0;
        client_stall = '0;
        client_dout  = '0;
        for (int j = 0; j < CLIENTS_N; j++) begin
            if (r_state[j] == c_ST_GRANT) begin
                alu_cycle[r_gnt_id[j]]                          = client_cycle[j];
                alu_strobe[r_gnt_id[j]]                         = client_strobe[j];
                alu_din[int'(r_gnt_id[j])*DIN_W +: DIN_W]       = client_din[j*DIN_W +: DIN_W];
                client_ack[j]                                   = alu_ack[r_gnt_id[j]];
                client_stall[j]                                 = alu_stall[r_gnt_id[j]];
                client_dout[j*DOUT_W +: DOUT_W]                 = alu_dout[int'(r_gnt_id[j])*DOUT_W +: DOUT_W];
            end else begin
                client_stall[j] = client_cycle[j];
            end
        end
    end

    generate
        for (genvar j = 0; j < CLIENTS_N; j++) begin : g_client_out
            assign client_gnt[j]                     = (r_state[j] == c_ST_GRANT);
            assign client_gnt_id[j*ALUS_W +: ALUS_W] = r_gnt_id[j];
        end
    endgenerate

    assign client_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_nic_rr.sv
// ============================================================================
// Module   : tb_alu_nic_rr
// Brief    : Self-checking bench for alu_nic_rr against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_nic_rr;

    localparam int N  = 3;
    localparam int A  = 2;
    localparam int AW = 1;
    localparam int DW = 210;
    localparam int OW = 96;
    localparam int TW = 8;
    localparam int T  = 4;

    localparam int M_IDLE  = 0;
    localparam int M_GRANT = 1;
    localparam int M_LOCK  = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    client_cycle = '0;
    logic [N-1:0]    client_strobe = '0;
    logic [N-1:0]    client_ack, client_stall, client_err, client_gnt;
    logic [DW*N-1:0] client_din = '0;
    logic [OW*N-1:0] client_dout;
    logic [AW*N-1:0] client_gnt_id;
    logic [A-1:0]    alu_cycle, alu_strobe;
    logic [A-1:0]    alu_ack = '0;
    logic [A-1:0]    alu_stall = '0;
    logic [DW*A-1:0] alu_din;
    logic [OW*A-1:0] alu_dout = '0;

    always #5 clk = ~clk;

    alu_nic_rr #(
        .CLIENTS_N(N), .ALUS_N(A), .ALUS_W(AW), .DIN_W(DW),
        .DOUT_W(OW), .TMO_W(TW), .TIMEOUT(T)
    ) dut (
        .clk(clk), .reset(reset),
        .client_cycle(client_cycle), .client_strobe(client_strobe),
        .client_ack(client_ack), .client_stall(client_stall), .client_err(client_err),
        .client_din(client_din), .client_dout(client_dout),
        .client_gnt(client_gnt), .client_gnt_id(client_gnt_id),
        .alu_cycle(alu_cycle), .alu_strobe(alu_strobe),
        .alu_ack(alu_ack), .alu_stall(alu_stall),
        .alu_din(alu_din), .alu_dout(alu_dout)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: who owns which ALU, per-client phase, watchdog counts
    int m_st  [N];
    int m_id  [N];
    bit m_err [N];
    int m_own [A];
    int m_cnt [A];
    int m_rr;

    logic         rst_nx;
    logic [N-1:0] cyc_nx, stb_nx;
    logic [A-1:0] ack_nx, stl_nx;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            m_st[j] = M_IDLE; m_id[j] = 0; m_err[j] = 1'b0;
        end
        for (int a = 0; a < A; a++) begin
            m_own[a] = -1; m_cnt[a] = 0;
        end
        m_rr = 0;
    endtask

    task automatic model_update();
        int st_old [N];
        int own_old [A];
        bit rel [A];
        int free_q [$];
        int j, a, last;
        bit any;
        st_old  = m_st;
        own_old = m_own;
        for (int i = 0; i < A; i++) rel[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_err[i] = 1'b0;
            if (st_old[i] == M_GRANT) begin
                if (!client_cycle[i] || m_cnt[m_id[i]] == T) begin
                    m_st[i] = client_cycle[i] ? M_LOCK : M_IDLE;
                    m_err[i] = client_cycle[i];
                    rel[m_id[i]] = 1'b1;
                    m_own[m_id[i]] = -1;
                    m_id[i] = 0;
                end
            end else if (st_old[i] == M_LOCK && !client_cycle[i]) begin
                m_st[i] = M_IDLE;
            end
        end
        for (int i = 0; i < A; i++) begin
            if (own_old[i] < 0 || rel[i])
                m_cnt[i] = 0;
            else if (client_cycle[own_old[i]] && alu_stall[i])
                m_cnt[i] = (m_cnt[i] < T) ? m_cnt[i] + 1 : T;
            else
                m_cnt[i] = 0;
            if (own_old[i] < 0) free_q.push_back(i);
        end
        any = 1'b0; last = 0;
        for (int k = 0; k < N; k++) begin
            j = (m_rr + k) % N;
            if (st_old[j] == M_IDLE && client_cycle[j] && free_q.size() > 0) begin
                a = free_q.pop_front();
                m_st[j] = M_GRANT; m_id[j] = a; m_own[a] = j;
                any = 1'b1; last = j;
            end
        end
        if (any) m_rr = (last + 1) % N;
    endtask

    task automatic compare_all();
        logic [N-1:0]  e_ack, e_stall, e_gnt, e_err;
        logic [A-1:0]  e_acyc, e_astb;
        logic [OW-1:0] e_dout;
        logic [DW-1:0] e_din;
        e_ack = '0; e_stall = '0; e_gnt = '0; e_err = '0; e_acyc = '0; e_astb = '0;
        for (int j = 0; j < N; j++) begin
            e_dout   = '0;
            e_gnt[j] = (m_st[j] == M_GRANT);
            e_err[j] = m_err[j];
            if (m_st[j] == M_GRANT) begin
                e_ack[j]   = alu_ack[m_id[j]];
                e_stall[j] = alu_stall[m_id[j]];
                e_dout     = alu_dout[m_id[j]*OW +: OW];
            end else begin
                e_stall[j] = client_cycle[j];
            end
            check_eq($sformatf("dout%0d", j), 256'(client_dout[j*OW +: OW]), 256'(e_dout));
            check_eq($sformatf("gnt_id%0d", j), 256'(client_gnt_id[j*AW +: AW]),
                     256'((m_st[j] == M_GRANT) ? m_id[j] : 0));
        end
        for (int a = 0; a < A; a++) begin
            e_din = '0;
            if (m_own[a] >= 0) begin
                e_acyc[a] = client_cycle[m_own[a]];
                e_astb[a] = client_strobe[m_own[a]];
                e_din     = client_din[m_own[a]*DW +: DW];
            end
            check_eq($sformatf("alu_din%0d", a), 256'(alu_din[a*DW +: DW]), 256'(e_din));
        end
        check_eq("ack",       256'(client_ack),   256'(e_ack));
        check_eq("stall",     256'(client_stall), 256'(e_stall));
        check_eq("gnt",       256'(client_gnt),   256'(e_gnt));
        check_eq("err",       256'(client_err),   256'(e_err));
        check_eq("alu_cycle", 256'(alu_cycle),    256'(e_acyc));
        check_eq("alu_strb",  256'(alu_strobe),   256'(e_astb));
    endtask

    // One clock: model follows the edge, new inputs at negedge, outputs checked 1 unit later.
    task automatic step();
        logic [639:0] rnd_c;
        logic [191:0] rnd_a;
        @(posedge clk);
        if (reset) model_update();
        @(negedge clk);
        for (int w = 0; w < 20; w++) rnd_c[w*32 +: 32] = $urandom;
        for (int w = 0; w < 6; w++)  rnd_a[w*32 +: 32] = $urandom;
        reset         = rst_nx;
        client_cycle  = cyc_nx;
        client_strobe = stb_nx;
        alu_ack       = ack_nx;
        alu_stall     = stl_nx;
        client_din    = rnd_c[DW*N-1:0];
        alu_dout      = rnd_a[OW*A-1:0];
        if (!reset) model_reset();
        #1;
        compare_all();
    endtask

    task automatic pulse_reset();
        rst_nx = 1'b0; step();
        rst_nx = 1'b1; step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  fair_cnt [N];
        int  ng;
        bit  seen;
        logic [N-1:0] prev;

        rst_nx = 1'b0; cyc_nx = '0; stb_nx = '0; ack_nx = '0; stl_nx = '0;
        model_reset();
        step(); step();
        check_eq("rst_gnt", 256'(client_gnt), 256'(0));
        check_eq("rst_err", 256'(client_err), 256'(0));
        rst_nx = 1'b1; step();

        // Single request from client 1
        cyc_nx = 3'b010; stb_nx = 3'b010; step();
        check_eq("one_stall_t0", 256'(client_stall[1]), 256'(1));
        check_eq("one_gnt_t0",   256'(client_gnt[1]),   256'(0));
        ack_nx = 2'b01; step();
        check_eq("one_gnt_t1", 256'(client_gnt[1]),    256'(1));
        check_eq("one_id_t1",  256'(client_gnt_id[1]), 256'(0));
        check_eq("one_din",    256'(alu_din[0 +: DW]), 256'(client_din[DW +: DW]));
        check_eq("one_ack",    256'(client_ack[1]),    256'(1));
        ack_nx = '0; cyc_nx = '0; stb_nx = '0; step(); step();

        // Contention among all three clients
        pulse_reset();
        cyc_nx = 3'b111; step();
        step();
        check_eq("cont_gnt_t1", 256'(client_gnt),       256'(3'b011));
        check_eq("cont_id1",    256'(client_gnt_id[1]), 256'(1));
        check_eq("cont_stall2", 256'(client_stall[2]),  256'(1));
        step(); step(); step();
        cyc_nx = 3'b110; step();
        step();
        check_eq("cont_gnt2_t6", 256'(client_gnt[2]), 256'(0));
        step();
        check_eq("cont_gnt2_t7", 256'(client_gnt[2]),    256'(1));
        check_eq("cont_id2_t7",  256'(client_gnt_id[2]), 256'(0));
        cyc_nx = '0; step(); step();

        // Fairness: drop one cycle after each grant, re-raise once idle
        pulse_reset();
        for (int j = 0; j < N; j++) fair_cnt[j] = 0;
        ng = 0; prev = '0; cyc_nx = '1;
        for (int c = 0; c < 80 && ng < 6; c++) begin
            step();
            for (int j = 0; j < N; j++) begin
                if (client_gnt[j] && !prev[j] && ng < 6) begin
                    fair_cnt[j]++; ng++;
                end
                if (client_gnt[j])                          cyc_nx[j] = 1'b0;
                else if (!client_cycle[j])                   cyc_nx[j] = 1'b1;
            end
            prev = client_gnt;
        end
        check_eq("fair_total", 256'(ng), 256'(6));
        for (int j = 0; j < N; j++)
            check_eq($sformatf("fair_c%0d", j), 256'(fair_cnt[j]), 256'(2));
        cyc_nx = '0; step(); step();

        // Stall timeout on ALU 1 owned by client 1
        pulse_reset();
        cyc_nx = 3'b011; step(); step();
        check_eq("to_id1", 256'(client_gnt_id[1]), 256'(1));
        stl_nx = 2'b10; seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            step();
            seen = client_err[1];
        end
        check_eq("to_err_seen", 256'(seen),            256'(1));
        check_eq("to_alu_cyc",  256'(alu_cycle[1]),    256'(0));
        check_eq("to_lock_stl", 256'(client_stall[1]), 256'(1));
        check_eq("to_ack",      256'(client_ack[1]),   256'(0));
        stl_nx = '0; step();
        check_eq("to_err_pulse", 256'(client_err[1]), 256'(0));
        check_eq("to_still_lock", 256'(client_gnt[1]), 256'(0));
        cyc_nx[1] = 1'b0; step();
        cyc_nx[1] = 1'b1; step(); step();
        check_eq("to_regrant", 256'(client_gnt[1]), 256'(1));

        // Reset while two grants are live
        check_eq("rmid_pre", 256'(client_gnt), 256'(3'b011));
        rst_nx = 1'b0; step();
        check_eq("rmid_acyc", 256'(alu_cycle),  256'(0));
        check_eq("rmid_gnt",  256'(client_gnt), 256'(0));
        cyc_nx = 3'b100; step();
        rst_nx = 1'b1; step(); step();
        check_eq("rmid_gnt2", 256'(client_gnt[2]),    256'(1));
        check_eq("rmid_id2",  256'(client_gnt_id[2]), 256'(0));

        // Randomized traffic with sticky requests and stall bursts
        for (int c = 0; c < 1500; c++) begin
            for (int j = 0; j < N; j++)
                if ($urandom_range(5) == 0) cyc_nx[j] = ~cyc_nx[j];
            for (int a = 0; a < A; a++)
                if ($urandom_range(4) == 0) stl_nx[a] = ~stl_nx[a];
            stb_nx = N'($urandom);
            ack_nx = A'($urandom);
            rst_nx = ($urandom_range(299) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
